// File: rtl/lcd_stream_pkg.sv
// Shared definitions for the KS0108-style streaming LCD controller.
//   - Panel command opcodes
//   - Controller FSM state and bus-phase enums
//   - cnt_width(): counter width helper, never narrower than one bit
// Optional feature macro: LCD_CLEAR_EN adds the panel-clear states to the FSM enum.
package lcd_stream_pkg;

    localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
    localparam logic [7:0] CMD_START_LINE = 8'hC0;
    localparam logic [7:0] CMD_PAGE       = 8'hB8;
    localparam logic [7:0] CMD_COL        = 8'h40;

    typedef enum logic [3:0] {
        StRstWait,
        StInitOn,
        StInitLine,
`ifdef LCD_CLEAR_EN
        StClrPage,
        StClrCol,
        StClrData,
`endif
        StSetPage,
        StSetCol,
        StWaitData,
        StWrite
    } lcd_state_e;

    typedef enum logic [1:0] {
        PhIdle,
        PhSetup,
        PhHigh,
        PhLow
    } bus_phase_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_stream_ctrl_if.sv
// Byte stream handshake between a frame source and lcd_stream_ctrl.
//   data        column byte, bit0 = top pixel of the page
//   data_valid  source holds a valid byte
//   data_ready  controller accepts the byte this cycle
// master = frame source, slave = controller.
interface lcd_stream_ctrl_if;

    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/lcd_bus_cycle.sv
// Timing engine for one LCD write strobe.
// A start pulse while idle runs SETUP (1 cycle, en low), HIGH (EN_HIGH_CYC cycles, en high) and
// LOW (EN_LOW_CYC cycles, en low). done_o pulses during the last LOW cycle so the owner can
// release chip select and pick the next cycle on the same edge. The owner drives cs/di/data.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        begin a bus cycle (ignored while busy)
//   en_o           LCD strobe
//   busy_o         a bus cycle is in progress
//   done_o         last cycle of the LOW phase
module lcd_bus_cycle
    import lcd_stream_pkg::*;
#(
    parameter int unsigned EN_HIGH_CYC = 2,
    parameter int unsigned EN_LOW_CYC  = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic en_o,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned MaxCyc = (EN_HIGH_CYC > EN_LOW_CYC) ? EN_HIGH_CYC : EN_LOW_CYC;
    localparam int unsigned CntW   = cnt_width(MaxCyc);

    bus_phase_e            phase_q, phase_d;
    logic       [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        unique case (phase_q)
            PhIdle: begin
                if (start_i) begin
                    phase_d = PhSetup;
                    cnt_d   = '0;
                end
            end
            PhSetup: begin
                phase_d = PhHigh;
                cnt_d   = '0;
            end
            PhHigh: begin
                if (cnt_q == CntW'(EN_HIGH_CYC - 1)) begin
                    phase_d = PhLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            PhLow: begin
                if (cnt_q == CntW'(EN_LOW_CYC - 1)) begin
                    phase_d = PhIdle;
                    cnt_d   = '0;
                    done_o  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                phase_d = PhIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PhIdle;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decoded straight from the phase flop so an asynchronous reset drops the strobe at once.
    assign en_o   = (phase_q == PhHigh);
    assign busy_o = (phase_q != PhIdle);

endmodule

// File: rtl/lcd_stream_ctrl.sv
// Write-only multi-chip KS0108-style graphic LCD controller fed by a byte stream.
// Holds the panel in reset, initialises every chip, then repeatedly writes frames in raster
// order: page 0..PAGES-1, per page chip 0..NUM_CS-1, per chip column 0..COLS_PER_CS-1.
// Each chip run is preceded by set-page and set-column commands; frame_done pulses once per frame.
// Optional feature macro: LCD_CLEAR_EN -- zero the whole panel (all chips at once) after init.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   stream       byte stream (slave modport): data, data_valid, data_ready
//   frame_done   one-cycle pulse after the last byte of a frame is written
//   LCD_rst      panel reset, active low
//   LCD_cs       one-hot / all-ones chip select, active high, 0 between bus cycles
//   LCD_rw       always 0
//   LCD_di       0 = command, 1 = display data
//   LCD_data     bus data
//   LCD_en       strobe, panel latches on the falling edge
module lcd_stream_ctrl
    import lcd_stream_pkg::*;
#(
    parameter int unsigned NUM_CS      = 2,
    parameter int unsigned PAGES       = 8,
    parameter int unsigned COLS_PER_CS = 64,
    parameter int unsigned EN_HIGH_CYC = 2,
    parameter int unsigned EN_LOW_CYC  = 2,
    parameter int unsigned RST_HOLD    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_stream_ctrl_if.slave    stream,
    output logic                frame_done,
    output logic                LCD_rst,
    output logic [NUM_CS-1:0]   LCD_cs,
    output logic                LCD_rw,
    output logic                LCD_di,
    output logic [7:0]          LCD_data,
    output logic                LCD_en
);

    localparam int unsigned PageW = cnt_width(PAGES);
    localparam int unsigned ColW  = cnt_width(COLS_PER_CS);
    localparam int unsigned ChipW = cnt_width(NUM_CS);
    localparam int unsigned RstW  = cnt_width(RST_HOLD);
    localparam logic [NUM_CS-1:0] CsOne = NUM_CS'(1);

    lcd_state_e              state_q, state_d;
    logic       [PageW-1:0]  page_q, page_d;
    logic       [ColW-1:0]   col_q, col_d;
    logic       [ChipW-1:0]  chip_q, chip_d;
    logic       [RstW-1:0]   rst_cnt_q, rst_cnt_d;
    logic       [7:0]        byte_q, byte_d;
    logic       [NUM_CS-1:0] cs_q, cs_d;
    logic                    di_q, di_d;
    logic       [7:0]        data_q, data_d;
    logic                    lcd_rst_q, lcd_rst_d;
    logic                    frame_done_q, frame_done_d;

    logic                    bus_start, bus_busy, bus_done, bus_en;
    logic                    ready;
    logic                    cyc_req;
    logic       [NUM_CS-1:0] cyc_cs;
    logic                    cyc_di;
    logic       [7:0]        cyc_data;

    lcd_bus_cycle #(
        .EN_HIGH_CYC (EN_HIGH_CYC),
        .EN_LOW_CYC  (EN_LOW_CYC)
    ) u_bus_cycle (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (bus_start),
        .en_o    (bus_en),
        .busy_o  (bus_busy),
        .done_o  (bus_done)
    );

    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        col_d        = col_q;
        chip_d       = chip_q;
        rst_cnt_d    = rst_cnt_q;
        byte_d       = byte_q;
        cs_d         = cs_q;
        di_d         = di_q;
        data_d       = data_q;
        lcd_rst_d    = lcd_rst_q;
        frame_done_d = 1'b0;
        bus_start    = 1'b0;
        ready        = 1'b0;
        // What the current state puts on the bus, if it owns a bus cycle.
        cyc_req      = 1'b1;
        cyc_cs       = CsOne << chip_q;
        cyc_di       = 1'b0;
        cyc_data     = '0;

        unique case (state_q)
            StRstWait: begin
                cyc_req = 1'b0;
                if (rst_cnt_q == RstW'(RST_HOLD - 1)) begin
                    lcd_rst_d = 1'b1;
                    state_d   = StInitOn;
                end else begin
                    rst_cnt_d = rst_cnt_q + RstW'(1);
                end
            end
            StInitOn: begin
                cyc_cs   = '1;
                cyc_data = CMD_DISP_ON;
                if (bus_done) state_d = StInitLine;
            end
            StInitLine: begin
                cyc_cs   = '1;
                cyc_data = CMD_START_LINE;
`ifdef LCD_CLEAR_EN
                if (bus_done) state_d = StClrPage;
`else
                if (bus_done) state_d = StSetPage;
`endif
            end
`ifdef LCD_CLEAR_EN
            StClrPage: begin
                cyc_cs   = '1;
                cyc_data = CMD_PAGE | 8'(page_q);
                if (bus_done) state_d = StClrCol;
            end
            StClrCol: begin
                cyc_cs   = '1;
                cyc_data = CMD_COL;
                if (bus_done) state_d = StClrData;
            end
            StClrData: begin
                cyc_cs   = '1;
                cyc_di   = 1'b1;
                cyc_data = 8'h00;
                if (bus_done) begin
                    if (col_q == ColW'(COLS_PER_CS - 1)) begin
                        col_d = '0;
                        if (page_q == PageW'(PAGES - 1)) begin
                            page_d  = '0;
                            state_d = StSetPage;
                        end else begin
                            page_d  = page_q + PageW'(1);
                            state_d = StClrPage;
                        end
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
`endif
            StSetPage: begin
                cyc_data = CMD_PAGE | 8'(page_q);
                if (bus_done) state_d = StSetCol;
            end
            StSetCol: begin
                cyc_data = CMD_COL;
                if (bus_done) state_d = StWaitData;
            end
            StWaitData: begin
                cyc_req = 1'b0;
                ready   = 1'b1;
                if (stream.data_valid) begin
                    byte_d  = stream.data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                cyc_di   = 1'b1;
                cyc_data = byte_q;
                if (bus_done) begin
                    if (col_q == ColW'(COLS_PER_CS - 1)) begin
                        col_d   = '0;
                        state_d = StSetPage;
                        if (chip_q == ChipW'(NUM_CS - 1)) begin
                            chip_d = '0;
                            if (page_q == PageW'(PAGES - 1)) begin
                                page_d       = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                page_d = page_q + PageW'(1);
                            end
                        end else begin
                            chip_d = chip_q + ChipW'(1);
                        end
                    end else begin
                        col_d   = col_q + ColW'(1);
                        state_d = StWaitData;
                    end
                end
            end
            default: begin
                cyc_req = 1'b0;
                state_d = StRstWait;
            end
        endcase

        // Bus signals are latched at start and held for the whole cycle; cs drops on completion.
        if (cyc_req && !bus_busy) begin
            bus_start = 1'b1;
            cs_d      = cyc_cs;
            di_d      = cyc_di;
            data_d    = cyc_data;
        end
        if (bus_done) cs_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRstWait;
            page_q       <= '0;
            col_q        <= '0;
            chip_q       <= '0;
            rst_cnt_q    <= '0;
            byte_q       <= '0;
            cs_q         <= '0;
            di_q         <= 1'b0;
            data_q       <= '0;
            lcd_rst_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            col_q        <= col_d;
            chip_q       <= chip_d;
            rst_cnt_q    <= rst_cnt_d;
            byte_q       <= byte_d;
            cs_q         <= cs_d;
            di_q         <= di_d;
            data_q       <= data_d;
            lcd_rst_q    <= lcd_rst_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign stream.data_ready = ready;
    assign frame_done        = frame_done_q;
    assign LCD_rst           = lcd_rst_q;
    assign LCD_cs            = cs_q;
    assign LCD_rw            = 1'b0;
    assign LCD_di            = di_q;
    assign LCD_data          = data_q;
    assign LCD_en            = bus_en;

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Bench for lcd_stream_ctrl: a table of expected per-cycle outputs for reset/init, a bus
// monitor that records every strobe and checks its timing, and a raster model that expands the
// accepted bytes into the full expected sequence of bus cycles.
module tb_lcd_stream_ctrl;

`ifdef LCD_CLEAR_EN
    localparam int unsigned NCS  = 3;
    localparam int unsigned NPG  = 2;
    localparam int unsigned NCOL = 4;
    localparam int CLR_BYTES = NPG * NCOL;
`else
    localparam int unsigned NCS  = 2;
    localparam int unsigned NPG  = 8;
    localparam int unsigned NCOL = 64;
    localparam int CLR_BYTES = 0;
`endif
    localparam int unsigned HI    = 2;
    localparam int unsigned LO    = 2;
    localparam int unsigned RH    = 16;
    localparam int unsigned T     = 1 + HI + LO;
    localparam int          FRAME = NCS * NPG * NCOL;
    localparam int ABORT_N = (FRAME > 300) ? 300 : FRAME - 3;

    logic           clk;
    logic           rst_n;
    logic           frame_done;
    logic           LCD_rst;
    logic [NCS-1:0] LCD_cs;
    logic           LCD_rw;
    logic           LCD_di;
    logic [7:0]     LCD_data;
    logic           LCD_en;

    lcd_stream_ctrl_if sif ();

    lcd_stream_ctrl #(
        .NUM_CS      (NCS),
        .PAGES       (NPG),
        .COLS_PER_CS (NCOL),
        .EN_HIGH_CYC (HI),
        .EN_LOW_CYC  (LO),
        .RST_HOLD    (RH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stream     (sif),
        .frame_done (frame_done),
        .LCD_rst    (LCD_rst),
        .LCD_cs     (LCD_cs),
        .LCD_rw     (LCD_rw),
        .LCD_di     (LCD_di),
        .LCD_data   (LCD_data),
        .LCD_en     (LCD_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reset/init table ----------------
    // d < 0 means di/data are don't-care (between bus cycles).
    typedef struct {
        int   n;
        logic rst;
        logic en;
        int   cs;
        int   di;
        int   d;
        logic rdy;
    } row_t;
    row_t tbl[$];

    // ---------------- bus monitor ----------------
    logic [NCS+8:0] obs_q[$];
    logic [NCS+8:0] exp_q[$];
    logic [7:0]     sent_q[$];
    logic           prev_en = 1'b0;
    logic [NCS-1:0] prev_cs = '0;
    int             hi_cnt = 0;
    int             run_len = 0;
    int             since_fall = 1000;
    int             data_seen = 0;
    int             fd_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            obs_q.delete();
            prev_en    = 1'b0;
            prev_cs    = '0;
            hi_cnt     = 0;
            run_len    = 0;
            since_fall = 1000;
            data_seen  = 0;
            fd_cnt     = 0;
        end else begin
            if (LCD_en) hi_cnt++;
            if (prev_en && !LCD_en) begin
                obs_q.push_back({LCD_cs, LCD_di, LCD_data});
                chk("en_high_len", hi_cnt, HI);
                hi_cnt     = 0;
                since_fall = 0;
                if (LCD_di) data_seen++;
            end else begin
                since_fall++;
            end
            if (LCD_cs != '0) begin
                if (run_len != 0) chk("cs_stable", LCD_cs, prev_cs);
                run_len++;
            end else if (run_len != 0) begin
                chk("cs_cycle_len", run_len, T);
                run_len = 0;
            end
            if (LCD_en) chk("en_has_cs", (LCD_cs != '0), 1);
            if (sif.data_ready) chk("ready_only_idle", {LCD_en, (LCD_cs != '0)}, 0);
            if (frame_done) begin
                fd_cnt++;
                chk("frame_done_after_low", since_fall, LO);
                chk("frame_done_at_frame_end",
                    (data_seen > CLR_BYTES) && ((data_seen - CLR_BYTES) % FRAME == 0), 1);
            end
            prev_en = LCD_en;
            prev_cs = LCD_cs;
        end
    end

    // ---------------- reference model ----------------
    // Expands the accepted bytes into the bus cycles the raster rules require.
    task automatic build_exp();
        logic [NCS-1:0] all_cs;
        logic [NCS-1:0] cs_v;
        int b, page, chip, col;
        all_cs = '1;
        exp_q.delete();
        exp_q.push_back({all_cs, 1'b0, 8'h3F});
        exp_q.push_back({all_cs, 1'b0, 8'hC0});
`ifdef LCD_CLEAR_EN
        for (int p = 0; p < int'(NPG); p++) begin
            exp_q.push_back({all_cs, 1'b0, 8'hB8 | 8'(p)});
            exp_q.push_back({all_cs, 1'b0, 8'h40});
            for (int c = 0; c < int'(NCOL); c++) exp_q.push_back({all_cs, 1'b1, 8'h00});
        end
`endif
        for (int g = 0; g <= sent_q.size(); g++) begin
            b    = g % FRAME;
            page = b / (NCS * NCOL);
            chip = (b / NCOL) % NCS;
            col  = b % NCOL;
            cs_v = '0;
            cs_v[chip] = 1'b1;
            if (col == 0) begin
                exp_q.push_back({cs_v, 1'b0, 8'hB8 | 8'(page)});
                exp_q.push_back({cs_v, 1'b0, 8'h40});
            end
            if (g < sent_q.size()) exp_q.push_back({cs_v, 1'b1, sent_q[g]});
        end
    endtask

    task automatic compare_model(input string tag);
        int local_err;
        build_exp();
        chk({tag, "_txn_count"}, obs_q.size(), exp_q.size());
        local_err = n_err;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_txn%0d", tag, i), obs_q[i], exp_q[i]);
            if (n_err - local_err >= 10) break;
        end
        chk({tag, "_frame_done_count"}, fd_cnt, sent_q.size() / FRAME);
    endtask

    // ---------------- stimulus ----------------
    task automatic stream_bytes(input int n, input int gap_pct);
        int         idx;
        int         guard;
        logic [7:0] b;
        logic       hs;
        idx   = 0;
        guard = 0;
        b     = 8'($urandom);
        while (idx < n && guard < n * 60 + 2000) begin
            @(negedge clk);
            if (int'($urandom_range(99)) >= gap_pct) begin
                sif.data_valid = 1'b1;
                sif.data       = b;
            end else begin
                sif.data_valid = 1'b0;
                sif.data       = 8'($urandom);
            end
            #1;
            hs = sif.data_valid && sif.data_ready;
            @(posedge clk);
            if (hs) begin
                sent_q.push_back(b);
                idx++;
                b = 8'($urandom);
            end
            guard++;
        end
        @(negedge clk);
        sif.data_valid = 1'b0;
        chk("stream_progress", idx, n);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"}, LCD_en, 0);
        chk({tag, "_cs"}, LCD_cs, 0);
        chk({tag, "_lcd_rst"}, LCD_rst, 0);
        chk({tag, "_di"}, LCD_di, 0);
        chk({tag, "_data"}, LCD_data, 0);
        chk({tag, "_rw"}, LCD_rw, 0);
        chk({tag, "_ready"}, sif.data_ready, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic release_and_init();
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[r]) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("init_r%0d_lcd_rst", r), LCD_rst, tbl[r].rst);
                chk($sformatf("init_r%0d_en", r), LCD_en, tbl[r].en);
                chk($sformatf("init_r%0d_cs", r), LCD_cs, tbl[r].cs);
                chk($sformatf("init_r%0d_ready", r), sif.data_ready, tbl[r].rdy);
                chk($sformatf("init_r%0d_frame_done", r), frame_done, 0);
                chk($sformatf("init_r%0d_rw", r), LCD_rw, 0);
                if (tbl[r].d >= 0) begin
                    chk($sformatf("init_r%0d_di", r), LCD_di, tbl[r].di);
                    chk($sformatf("init_r%0d_data", r), LCD_data, tbl[r].d);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        sent_q.delete();
        release_and_init();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int all_cs;
        int w;
        all_cs = (1 << NCS) - 1;
        //            n       rst   en    cs      di d      rdy
        tbl.push_back('{RH - 1, 1'b0, 1'b0, 0,      0, 0,     1'b0});
        tbl.push_back('{1,      1'b1, 1'b0, 0,      0, 0,     1'b0});
        tbl.push_back('{1,      1'b1, 1'b0, all_cs, 0, 'h3F,  1'b0});
        tbl.push_back('{HI,     1'b1, 1'b1, all_cs, 0, 'h3F,  1'b0});
        tbl.push_back('{LO,     1'b1, 1'b0, all_cs, 0, 'h3F,  1'b0});
        tbl.push_back('{1,      1'b1, 1'b0, 0,      0, -1,    1'b0});
        tbl.push_back('{1,      1'b1, 1'b0, all_cs, 0, 'hC0,  1'b0});
        tbl.push_back('{HI,     1'b1, 1'b1, all_cs, 0, 'hC0,  1'b0});
        tbl.push_back('{LO,     1'b1, 1'b0, all_cs, 0, 'hC0,  1'b0});
        tbl.push_back('{1,      1'b1, 1'b0, 0,      0, -1,    1'b0});
`ifndef LCD_CLEAR_EN
        tbl.push_back('{1,      1'b1, 1'b0, 1,      0, 'hB8,  1'b0});
        tbl.push_back('{HI,     1'b1, 1'b1, 1,      0, 'hB8,  1'b0});
        tbl.push_back('{LO,     1'b1, 1'b0, 1,      0, 'hB8,  1'b0});
        tbl.push_back('{1,      1'b1, 1'b0, 0,      0, -1,    1'b0});
        tbl.push_back('{1,      1'b1, 1'b0, 1,      0, 'h40,  1'b0});
        tbl.push_back('{HI,     1'b1, 1'b1, 1,      0, 'h40,  1'b0});
        tbl.push_back('{LO,     1'b1, 1'b0, 1,      0, 'h40,  1'b0});
        tbl.push_back('{1,      1'b1, 1'b0, 0,      0, -1,    1'b1});
`endif

        sif.data_valid = 1'b0;
        sif.data       = 8'h00;

        // Power-up reset, init, one full frame back-to-back, then random backpressure.
        do_reset();
        stream_bytes(FRAME + 5, 0);
        stream_bytes(FRAME / 2 + 13, 50);
        repeat (8 * (T + 2)) @(posedge clk);
        compare_model("run1");

        // Reset in the HIGH phase of a data write mid-frame.
        do_reset();
        stream_bytes(ABORT_N, 0);
        w = 0;
        while (w < 4 * int'(T)) begin
            @(posedge clk);
            #1;
            if (LCD_en) break;
            w++;
        end
        chk("abort_reached_high", LCD_en, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("abort_hold");
        sent_q.delete();
        release_and_init();
        stream_bytes(70, 40);
        repeat (8 * (T + 2)) @(posedge clk);
        compare_model("run2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
